// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//
// Instruction-side responder for the CPU fetch port. Holds the instruction
// memory in an internal RAM, answers fetches with a one-cycle registered read,
// and accepts a word-streaming program load that rewrites the RAM from word 0.
// While a load is in progress the CPU is held off through stall_req.
//
// Ports:
//   clk         system clock, everything on the rising edge
//   rst         synchronous, active-high reset
//   ce          fetch enable from the CPU
//   addr        fetch byte address from the CPU
//   inst        fetched instruction (registered, 0 when not a good fetch)
//   inst_valid  inst answers the fetch issued in the previous cycle
//   addr_err    one-cycle pulse: previous fetch was misaligned or out of range
//   stall_req   high while a load is in progress (LOAD and DONE)
//   load_start  one-cycle request to begin a program load at word 0
//   load_valid  load_data is valid this cycle
//   load_data   program word
//   load_last   qualifies load_valid, marks the final word
//   load_ready  block accepts a load word this cycle (LOAD only)
//   load_done   one-cycle pulse when a load completes
//   load_count  words written by the last or current load
//   dbg_state   current FSM state (SERVE=0, LOAD=1, DONE=2) for observation
//
// Load handshake: a word is transferred on every rising edge where
// load_ready=1 and load_valid=1. load_valid outside LOAD is ignored, and
// gaps (load_valid=0) inside LOAD are allowed indefinitely.
// ---------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [31:0]       addr,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              addr_err,
    output logic              stall_req,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wptr;

    // Fetch qualification: word aligned and no address bits above the RAM.
    logic              fetch_aligned;
    logic              fetch_in_range;
    logic              fetch_good;
    logic [ADDR_W-1:0] fetch_idx;

    assign fetch_aligned  = (addr[1:0] == 2'b00);
    assign fetch_in_range = (addr[31:ADDR_W+2] == '0);
    assign fetch_good     = fetch_aligned && fetch_in_range;
    assign fetch_idx      = addr[ADDR_W+1:2];

    // Writes only happen in LOAD, where reads are suppressed, so the RAM
    // never sees a read and a write to the same word in one cycle.
    logic wr_en;
    logic wr_final;

    assign wr_en    = (state == LOAD) && load_valid;
    // The load ends on an explicit last word or when the top word is
    // written; the pointer wrapping to 0 afterwards is never used.
    assign wr_final = wr_en && (load_last || (wptr == ADDR_W'(DEPTH - 1)));

    // RAM array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= load_data;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SERVE;
            inst       <= '0;
            inst_valid <= 1'b0;
            addr_err   <= 1'b0;
            stall_req  <= 1'b0;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            load_count <= '0;
            wptr       <= '0;
        end else begin
            case (state)
                SERVE: begin
                    load_done  <= 1'b0;
                    stall_req  <= 1'b0;
                    load_ready <= 1'b0;
                    // A fetch is served even in the cycle load_start arrives.
                    if (ce) begin
                        inst_valid <= 1'b1;
                        if (fetch_good) begin
                            inst     <= mem[fetch_idx];
                            addr_err <= 1'b0;
                        end else begin
                            inst     <= '0;
                            addr_err <= 1'b1;
                        end
                    end else begin
                        inst       <= '0;
                        inst_valid <= 1'b0;
                        addr_err   <= 1'b0;
                    end
                    if (load_start) begin
                        state      <= LOAD;
                        wptr       <= '0;
                        load_count <= '0;
                        load_ready <= 1'b1;
                        stall_req  <= 1'b1;
                    end
                end

                LOAD: begin
                    inst       <= '0;
                    inst_valid <= 1'b0;
                    addr_err   <= 1'b0;
                    // load_start is deliberately ignored here.
                    if (wr_en) begin
                        wptr       <= wptr + 1'b1;
                        load_count <= load_count + 1'b1;
                    end
                    if (wr_final) begin
                        state      <= DONE;
                        load_ready <= 1'b0;
                        load_done  <= 1'b1;
                    end
                end

                DONE: begin
                    inst       <= '0;
                    inst_valid <= 1'b0;
                    addr_err   <= 1'b0;
                    load_done  <= 1'b0;
                    stall_req  <= 1'b0;
                    load_ready <= 1'b0;
                    state      <= SERVE;
                end

                default: begin
                    state <= SERVE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Directed bench for inst_mem_loader. Fetch tasks push the expected
// {addr_err, inst} into exp_q; a monitor on the falling edge pops one entry
// for every cycle the DUT shows inst_valid. Load and control outputs are
// checked directly against hand-computed values after each step.
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk;
    logic              rst;
    logic              ce;
    logic [31:0]       addr;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              addr_err;
    logic              stall_req;
    logic              load_start;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic [1:0]        dbg_state;

    logic [32:0]       exp_q[$];
    logic [32:0]       mon_exp;
    int                checks;
    int                fails;

    inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .addr       (addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .addr_err   (addr_err),
        .stall_req  (stall_req),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_count (load_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic fetch(input logic [31:0] a, input logic [32:0] e);
        ce   = 1'b1;
        addr = a;
        exp_q.push_back(e);
        cycle();
        ce   = 1'b0;
        addr = '0;
    endtask

    task automatic load_begin();
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        check("load_enter_ready", load_ready, 1);
        check("load_enter_stall", stall_req, 1);
        check("load_enter_state", dbg_state, 1);
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        cycle();
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (inst_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_inst: got inst=0x%0h err=%0b, expected no valid output at %0t",
                             inst, addr_err, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("fetch_resp", {31'd0, addr_err, inst}, {31'd0, mon_exp});
                end
            end else begin
                check("idle_resp", {31'd0, addr_err, inst}, 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks     = 0;
        fails      = 0;
        rst        = 1'b1;
        ce         = 1'b0;
        addr       = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;

        // Reset values
        repeat (3) cycle();
        check("rst_inst", inst, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_stall", stall_req, 0);
        check("rst_ready", load_ready, 0);
        check("rst_done", load_done, 0);
        check("rst_count", load_count, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        cycle();

        // Place 0x34011100 at word 0, then fetch it
        load_begin();
        push_word(32'h3401_1100, 1'b1);
        check("t1_done", load_done, 1);
        check("t1_count", load_count, 1);
        cycle();
        fetch(32'h0, {1'b0, 32'h3401_1100});
        cycle();

        // Three-word load with a gap before the second word
        load_begin();
        push_word(32'hA, 1'b0);
        check("t2_ready_a", load_ready, 1);
        cycle();
        check("t2_ready_gap", load_ready, 1);
        check("t2_stall_gap", stall_req, 1);
        check("t2_no_done_gap", load_done, 0);
        push_word(32'hB, 1'b0);
        check("t2_ready_b", load_ready, 1);
        push_word(32'hC, 1'b1);
        check("t2_done", load_done, 1);
        check("t2_done_ready", load_ready, 0);
        check("t2_done_stall", stall_req, 1);
        check("t2_count", load_count, 3);
        check("t2_done_state", dbg_state, 2);
        cycle();
        check("t2_done_pulse_end", load_done, 0);
        check("t2_serve_stall", stall_req, 0);
        check("t2_serve_ready", load_ready, 0);
        check("t2_count_hold", load_count, 3);
        fetch(32'h0, {1'b0, 32'hA});
        fetch(32'h4, {1'b0, 32'hB});
        fetch(32'h8, {1'b0, 32'hC});
        cycle();

        // Misaligned and out-of-range fetches
        fetch(32'h2, {1'b1, 32'h0});
        fetch(32'h1000, {1'b1, 32'h0});
        cycle();
        check("t3_err_one_cycle", addr_err, 0);
        fetch(32'h8000_0004, {1'b1, 32'h0});
        fetch(32'h4, {1'b0, 32'hB});
        cycle();

        // Full-depth stream without load_last
        load_begin();
        for (int i = 0; i < DEPTH; i++) begin
            push_word(32'hD000_0000 | 32'(i), 1'b0);
            if (i == 500) begin
                check("t4_mid_count", load_count, 501);
                check("t4_mid_ready", load_ready, 1);
            end
        end
        check("t4_done", load_done, 1);
        check("t4_count", load_count, 1024);
        check("t4_done_ready", load_ready, 0);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        cycle();
        check("t4_drop_count_a", load_count, 1024);
        check("t4_serve_ready", load_ready, 0);
        check("t4_serve_stall", stall_req, 0);
        cycle();
        load_valid = 1'b0;
        load_data  = '0;
        check("t4_drop_count_b", load_count, 1024);
        fetch(32'h0, {1'b0, 32'hD000_0000});
        fetch(32'hFFC, {1'b0, 32'hD000_03FF});
        fetch(32'h7F8, {1'b0, 32'hD000_01FE});
        cycle();

        // Fetch during LOAD and an ignored load_start mid-load
        load_begin();
        ce   = 1'b1;
        addr = 32'h0;
        push_word(32'h100, 1'b0);
        check("t5_stall_a", stall_req, 1);
        check("t5_no_valid_a", inst_valid, 0);
        push_word(32'h101, 1'b0);
        load_start = 1'b1;
        push_word(32'h102, 1'b0);
        load_start = 1'b0;
        check("t5_count_cont", load_count, 3);
        check("t5_state_load", dbg_state, 1);
        check("t5_stall_b", stall_req, 1);
        check("t5_no_valid_b", inst_valid, 0);
        push_word(32'h103, 1'b1);
        check("t5_done", load_done, 1);
        check("t5_count", load_count, 4);
        ce = 1'b0;
        cycle();
        fetch(32'h0, {1'b0, 32'h100});
        fetch(32'h4, {1'b0, 32'h101});
        fetch(32'h8, {1'b0, 32'h102});
        fetch(32'hC, {1'b0, 32'h103});
        cycle();

        // Reset in the middle of a load
        load_begin();
        push_word(32'h200, 1'b0);
        push_word(32'h201, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_state", dbg_state, 0);
        check("t6_ready", load_ready, 0);
        check("t6_stall", stall_req, 0);
        check("t6_count", load_count, 0);
        check("t6_done", load_done, 0);
        cycle();
        check("t6_done_after", load_done, 0);
        fetch(32'h0, {1'b0, 32'h200});
        fetch(32'h4, {1'b0, 32'h201});
        fetch(32'h8, {1'b0, 32'h102});
        cycle();

        // Fetch issued together with load_start is still served
        ce         = 1'b1;
        addr       = 32'h4;
        load_start = 1'b1;
        exp_q.push_back({1'b0, 32'h201});
        cycle();
        ce         = 1'b0;
        load_start = 1'b0;
        check("t7_state_load", dbg_state, 1);
        push_word(32'h300, 1'b1);
        cycle();
        fetch(32'h0, {1'b0, 32'h300});
        cycle();

        repeat (2) cycle();
        check("queue_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Instruction-side responder for the CPU fetch port (rom_addr_o / rom_ce_o to rom_data_i).
- Holds the instruction memory in an internal RAM and returns fetched words with a registered read.
- Adds a word-streaming program-load port, so a host or boot block can write the program at run time.
- While a load is in progress, fetches are held off with a stall request.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2^ADDR_W words.
- DEPTH, 1024, number of 32-bit words; must equal 2^ADDR_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  fetch enable from CPU.
- addr  in  32  fetch byte address from CPU.
- inst  out  32  fetched instruction, registered.
- inst_valid  out  1  inst holds data for the fetch issued in the previous cycle.
- addr_err  out  1  one-cycle pulse: previous fetch was misaligned or out of range.
- stall_req  out  1  high while a load is in progress; the CPU must not consume inst.
- load_start  in  1  one-cycle request to begin a program load at word 0.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  32  program word.
- load_last  in  1  qualifies load_valid; marks the final word.
- load_ready  out  1  block accepts a load word this cycle.
- load_done  out  1  one-cycle pulse when a load completes.
- load_count  out  ADDR_W+1  number of words written by the last or current load.

Behaviour:
- Reset (synchronous, active-high): all of these are 0: inst, inst_valid, addr_err, stall_req, load_ready, load_done, load_count, write pointer. State goes to SERVE. RAM contents are not cleared.
- Reset during LOAD aborts the load. Words already written stay in RAM. load_done does not pulse.
- State SERVE:
  - A fetch is "good" when ce=1, addr[1:0]=0 and addr[31:ADDR_W+2]=0.
  - Good fetch: next cycle inst = mem[addr[ADDR_W+1:2]], inst_valid=1, addr_err=0. Latency is exactly 1 cycle; back-to-back fetches give one word per cycle.
  - ce=1 with a misaligned or out-of-range address: next cycle inst=0 (NOP), inst_valid=1, addr_err=1.
  - ce=0: next cycle inst=0, inst_valid=0, addr_err=0.
  - load_start=1: go to LOAD next cycle. Write pointer and load_count are cleared.
  - A fetch presented in the same cycle as load_start is still served normally.
- State LOAD:
  - load_ready=1 and stall_req=1.
  - inst=0 and inst_valid=0 regardless of ce. No addr_err is raised.
  - Each cycle with load_valid=1: write mem[wptr]=load_data, then wptr+1 and load_count+1.
  - Leave to DONE when load_valid & load_last, or when a write lands in word DEPTH-1. That final word is written.
  - load_start during LOAD is ignored.
  - load_valid=0 cycles insert gaps with no time limit.
- State DONE (one cycle):
  - load_ready=0, stall_req=1, load_done=1.
  - load_count holds its final value until the next load_start.
  - Next state is SERVE.
  - The first fetch accepted in SERVE reads the new contents, including the last word written.
- A load_valid arriving outside LOAD is dropped: no write and no count change.
- In SERVE, stall_req=0 and load_ready=0.
- Read-during-write cannot happen: writes occur only in LOAD, where reads are suppressed.

Test Plan:
- Reset, then ce=1, addr=0x0 with mem[0]=0x34011100 (preloaded) -> the cycle after the fetch: inst=0x34011100, inst_valid=1. All outputs were 0 during reset.
- Load 3 words 0xA, 0xB, 0xC with load_last on the third and one idle gap before the second -> load_ready=1 throughout LOAD, load_done pulses once, load_count=3. Then fetches at 0x0, 0x4, 0x8 back-to-back -> inst = 0xA, 0xB, 0xC on consecutive cycles.
- Fetch at addr=0x2 and at addr=0x1000 (beyond 4 KB) -> inst=0, inst_valid=1, addr_err=1 for one cycle each.
- Stream DEPTH words without load_last -> automatic DONE after word 1023, load_count=1024. A further load_valid is dropped, and mem[0] keeps the first streamed value.
- ce=1 during LOAD -> inst_valid=0 and stall_req=1 throughout. load_start mid-load is ignored, so load_count continues from its current value.
- Assert rst after 2 of 5 load words -> next cycle: state SERVE, load_ready=0, stall_req=0, load_count=0, no load_done. Words 0 and 1 are readable with their new values.
